// File: rtl/mfp_reset_button.sv
// rtl/mfp_reset_button.sv - pushbutton to soft/cold reset request generator
//
// Purpose: synchronises and debounces a raw pushbutton. A short press
// produces a PULSE_CYCLES-wide rst_soft pulse after release. A long press
// produces a PULSE_CYCLES-wide rst_cold pulse once the hold reaches LONG_CYCLES.
//
// Optional feature macro: MFP_RESET_BUTTON_LONG_PRESS_EN
//   defined   - long-press cold reset is enabled (hold counter, COLD_PULSE,
//               WAIT_RELEASE are present)
//   undefined - rst_cold is tied to 0 and every press ends in a soft pulse
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   pin_button in   raw bouncing pushbutton (polarity per BUTTON_ACTIVE_LOW)
//   rst_soft   out  registered soft-reset request, active high
//   rst_cold   out  registered cold-reset request, active high
//   pressed    out  registered debounced button level, 1 = pressed
module mfp_reset_button #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_CYCLES       = 100000000,
    parameter int PULSE_CYCLES      = 16,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_button,
    output logic rst_soft,
    output logic rst_cold,
    output logic pressed
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
    // Pin level seen while the button is not pressed.
    localparam logic PIN_RELEASED = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HELD,
        ST_SOFT_PULSE
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
        ,
        ST_COLD_PULSE,
        ST_WAIT_RELEASE
`endif
    } state_t;

    // Synchroniser
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Debouncer
    logic            btn_level;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pressed_q, pressed_d;

    // FSM
    state_t               state_q, state_d;
    logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic                 rst_soft_q, rst_soft_d;

`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 rst_cold_q, rst_cold_d;
`endif

    always_comb begin
        sync1_d = pin_button;
        sync2_d = sync1_q;
    end

    // The count only advances while the synchronised level disagrees with the
    // accepted level; any agreeing cycle (a bounce) restarts it from zero.
    always_comb begin
        btn_level = sync2_q ^ PIN_RELEASED;
        db_cnt_d  = '0;
        pressed_d = pressed_q;
        if (btn_level != pressed_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                pressed_d = ~pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                pulse_cnt_d = '0;
                if (pressed_q) begin
                    state_d = ST_HELD;
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_HELD: begin
                pulse_cnt_d = '0;
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
                // Long-hold test comes first so a release landing on the final
                // hold cycle is still treated as a long press.
                if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
                    state_d = ST_COLD_PULSE;
                end else if (!pressed_q) begin
                    state_d = ST_SOFT_PULSE;
                end else if (hold_cnt_q != HOLD_W'(LONG_CYCLES)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`else
                if (!pressed_q) begin
                    state_d = ST_SOFT_PULSE;
                end
`endif
            end
            ST_SOFT_PULSE: begin
                if (pulse_cnt_q == PULSE_W'(PULSE_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    pulse_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
            ST_COLD_PULSE: begin
                // Button is deliberately ignored until the pulse completes.
                if (pulse_cnt_q == PULSE_W'(PULSE_CYCLES - 1)) begin
                    state_d     = ST_WAIT_RELEASE;
                    pulse_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
            ST_WAIT_RELEASE: begin
                // Release of a long press returns silently, no soft pulse.
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                pulse_cnt_d = '0;
            end
        endcase
    end

    // Outputs decode the next state so they rise on the same edge the FSM
    // enters the pulse state.
    always_comb begin
        rst_soft_d = (state_d == ST_SOFT_PULSE);
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
        rst_cold_d = (state_d == ST_COLD_PULSE);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= PIN_RELEASED;
            sync2_q     <= PIN_RELEASED;
            db_cnt_q    <= '0;
            pressed_q   <= 1'b0;
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            rst_soft_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            pressed_q   <= pressed_d;
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            rst_soft_q  <= rst_soft_d;
        end
    end

`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt_q <= '0;
            rst_cold_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rst_cold_q <= rst_cold_d;
        end
    end

    assign rst_cold = rst_cold_q;
`else
    assign rst_cold = 1'b0;
`endif

    assign rst_soft = rst_soft_q;
    assign pressed  = pressed_q;

endmodule

// File: tb/tb_mfp_reset_button.sv
// tb/tb_mfp_reset_button.sv - directed self-checking bench for mfp_reset_button
module tb_mfp_reset_button;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pin_button = 1'b1;
    logic rst_soft;
    logic rst_cold;
    logic pressed;

    int checks = 0;
    int errors = 0;

    mfp_reset_button #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_CYCLES      (20),
        .PULSE_CYCLES     (3),
        .BUTTON_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pin_button(pin_button),
        .rst_soft  (rst_soft),
        .rst_cold  (rst_cold),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        resetn = 1'b0;
        pin_button = 1'b1;
        repeat (3) tick();
        obs = {pressed, rst_soft, rst_cold};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_active obs {pressed,soft,cold}=%b exp=000", obs);
        end
        resetn = 1'b1;
        repeat (4) tick();
        obs = {pressed, rst_soft, rst_cold};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_released obs {pressed,soft,cold}=%b exp=000", obs);
        end
    endtask

    // 10-cycle press then release: pressed at +6, soft pulse 7..9 after release.
    task automatic test_short_press(input string name);
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(p >= 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s_press cyc %0d obs {pressed,soft,cold}=%b exp=%b", name, p, obs, exp);
            end
        end
        pin_button = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(r < 6), (r >= 7 && r <= 9), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s_release cyc %0d obs {pressed,soft,cold}=%b exp=%b", name, r, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] obs;
        for (int i = 0; i < 40; i++) begin
            pin_button = ((i >> 1) & 1) != 0;
            tick();
            obs = {pressed, rst_soft, rst_cold};
            checks++;
            if (obs !== 3'b000) begin
                errors++;
                $display("FAIL bounce cyc %0d obs {pressed,soft,cold}=%b exp=000", i, obs);
            end
        end
        pin_button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            checks++;
            if (obs !== 3'b000) begin
                errors++;
                $display("FAIL bounce_settle cyc %0d obs {pressed,soft,cold}=%b exp=000", i, obs);
            end
        end
    endtask

`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
    // pressed rises at 6, cold pulse at 27..29 (21 after pressed), silent release.
    task automatic test_long_press();
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        for (int p = 1; p <= 60; p++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(p >= 6), 1'b0, (p >= 27 && p <= 29)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_press cyc %0d obs {pressed,soft,cold}=%b exp=%b", p, obs, exp);
            end
        end
        pin_button = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(r < 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_release cyc %0d obs {pressed,soft,cold}=%b exp=%b", r, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        for (int p = 1; p <= 28; p++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(p >= 6), 1'b0, (p >= 27)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midpulse_press cyc %0d obs {pressed,soft,cold}=%b exp=%b", p, obs, exp);
            end
        end
        resetn = 1'b0;
        pin_button = 1'b1;
        #1;
        obs = {pressed, rst_soft, rst_cold};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL midpulse_async_clear obs {pressed,soft,cold}=%b exp=000", obs);
        end
        repeat (2) tick();
        resetn = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            checks++;
            if (obs !== 3'b000) begin
                errors++;
                $display("FAIL midpulse_no_replay cyc %0d obs {pressed,soft,cold}=%b exp=000", n, obs);
            end
        end
    endtask
`else
    task automatic test_long_no_cold();
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        for (int p = 1; p <= 60; p++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(p >= 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL nocold_press cyc %0d obs {pressed,soft,cold}=%b exp=%b", p, obs, exp);
            end
        end
        pin_button = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(r < 6), (r >= 7 && r <= 9), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL nocold_release cyc %0d obs {pressed,soft,cold}=%b exp=%b", r, obs, exp);
            end
        end
    endtask
`endif

    // Re-press during the soft pulse: pressed returns at 10 while the pulse ends,
    // so IDLE must immediately take a new press and later emit a second pulse.
    task automatic test_back_to_back();
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(p >= 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_press cyc %0d obs {pressed,soft,cold}=%b exp=%b", p, obs, exp);
            end
        end
        pin_button = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {((n < 6) || (n >= 10)), (n >= 7 && n <= 9), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_repress cyc %0d obs {pressed,soft,cold}=%b exp=%b", n, obs, exp);
            end
            if (n == 4) pin_button = 1'b0;
        end
        pin_button = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(r < 6), (r >= 7 && r <= 9), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_second_release cyc %0d obs {pressed,soft,cold}=%b exp=%b", r, obs, exp);
            end
        end
    endtask

    task automatic test_reset_held();
        logic [2:0] obs, exp;
        pin_button = 1'b0;
        resetn = 1'b0;
        repeat (3) tick();
        obs = {pressed, rst_soft, rst_cold};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL held_in_reset obs {pressed,soft,cold}=%b exp=000", obs);
        end
        resetn = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            obs = {pressed, rst_soft, rst_cold};
            exp = {(n >= 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL held_after_reset cyc %0d obs {pressed,soft,cold}=%b exp=%b", n, obs, exp);
            end
        end
        pin_button = 1'b1;
        repeat (20) tick();
        obs = {pressed, rst_soft, rst_cold};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL held_final_idle obs {pressed,soft,cold}=%b exp=000", obs);
        end
    endtask

    initial begin
        test_reset();
        test_short_press("short");
        repeat (5) tick();
        test_bounce();
        repeat (5) tick();
`ifdef MFP_RESET_BUTTON_LONG_PRESS_EN
        test_long_press();
        repeat (5) tick();
        test_short_press("after_long");
        repeat (5) tick();
        test_reset_mid_pulse();
`else
        test_long_no_cold();
`endif
        repeat (5) tick();
        test_back_to_back();
        repeat (5) tick();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfp_reset_button.md
MFP_RESET_BUTTON -- requirements
Module: mfp_reset_button

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable cycles needed to accept a button level change.
REQ-002 Parameter LONG_CYCLES, default 100000000, SHALL set the debounced hold length that classifies a press as long.
REQ-003 Parameter PULSE_CYCLES, default 16, SHALL set the width of each reset output pulse in clk cycles (minimum 1).
REQ-004 Parameter BUTTON_ACTIVE_LOW, default 1, SHALL select raw pin polarity (1: pressed = 0).
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 pin_button  input  1  raw, asynchronous, bouncing pushbutton.
REQ-008 rst_soft  output  1  registered active-high soft-reset request, feeds the reset controller's soft-reset pin.
REQ-009 rst_cold  output  1  registered active-high cold-reset request, feeds the reset controller's cold-reset pin.
REQ-010 pressed  output  1  registered debounced button level, 1 = pressed.

Function
REQ-011 pin_button SHALL pass through a 2-flop synchronizer, then be normalised to 1 = pressed per BUTTON_ACTIVE_LOW.
REQ-012 Debouncer: counter SHALL clear whenever the synchronized level equals pressed; pressed SHALL flip on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, with the counter cleared at that edge.
REQ-013 Any agreeing cycle (bounce) SHALL restart the debounce count from 0.
REQ-014 FSM states: IDLE, HELD, SOFT_PULSE, COLD_PULSE, WAIT_RELEASE; encoding free.
REQ-015 IDLE: pressed = 1 -> HELD with hold counter cleared; otherwise remain.
REQ-016 HELD: hold counter SHALL increment once per cycle while pressed = 1, saturating, width $clog2(LONG_CYCLES+1).
REQ-017 HELD: pressed = 0 before the count reaches LONG_CYCLES -> SOFT_PULSE.
REQ-018 HELD: count reaching LONG_CYCLES while pressed = 1 -> COLD_PULSE (feature per REQ-028); if both happen in the same cycle, the cold transition SHALL win.
REQ-019 SOFT_PULSE: rst_soft = 1 for exactly PULSE_CYCLES cycles, then IDLE.
REQ-020 COLD_PULSE: rst_cold = 1 for exactly PULSE_CYCLES cycles, then WAIT_RELEASE; the button SHALL NOT be sampled during the pulse.
REQ-021 WAIT_RELEASE: pressed = 0 -> IDLE; release from a long press SHALL NOT produce rst_soft.
REQ-022 Returning to IDLE with pressed still 1 SHALL enter HELD on the next cycle (new press).
REQ-023 rst_soft and rst_cold SHALL never be 1 in the same cycle.
REQ-024 Outputs SHALL be registered state decodes: rst_soft rises on the first clk edge after the debounced release, and rst_cold rises on the first edge after the hold reaches LONG_CYCLES.

Reset
REQ-025 resetn = 0 SHALL asynchronously force rst_soft = 0, rst_cold = 0, pressed = 0, state IDLE, all counters 0, and synchronizer flops to the released pin level.
REQ-026 resetn asserted mid-pulse SHALL terminate the pulse immediately; after release, no pulse SHALL resume or replay.
REQ-027 After resetn deasserts with the button held, a press SHALL be recognised only after full synchronization and debounce (2 + DEBOUNCE_CYCLES cycles).

Configuration
REQ-028 Macro MFP_RESET_BUTTON_LONG_PRESS_EN defined: long-press cold reset SHALL operate per REQ-016..REQ-021.
REQ-029 Macro undefined: rst_cold SHALL be constant 0, COLD_PULSE/WAIT_RELEASE and the hold counter SHALL be omitted, and HELD SHALL exit only on release -> SOFT_PULSE, regardless of press duration.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, PULSE_CYCLES=3, BUTTON_ACTIVE_LOW=1, macro defined unless stated)
REQ-030 Hold pin_button = 0 for 10 cycles, then 1 -> pressed rises 6 cycles after the fall (2 sync + 4 debounce); rst_soft = 1 for exactly 3 cycles after the debounced release; rst_cold stays 0.
REQ-031 Toggle pin_button every 2 cycles for 40 cycles -> pressed, rst_soft, and rst_cold remain 0 throughout.
REQ-032 Hold pin_button = 0 for 60 cycles, then release -> rst_cold = 1 for 3 cycles starting 21 cycles after pressed rises; no rst_soft on release; FSM back in IDLE after debounced release.
REQ-033 Assert resetn = 0 during the second rst_cold pulse cycle -> rst_cold = 0 the same cycle; after resetn = 1 with the pin released, no further pulses.
REQ-034 Macro undefined, hold 60 cycles then release -> rst_cold never 1; one 3-cycle rst_soft pulse after the debounced release.
